// File: rtl/vc_test_sink_rand.sv
// rtl/vc_test_sink_rand.sv - val/rdy test sink with loadable expected messages, random stalls and error counting
module vc_test_sink_rand #(
    parameter int unsigned p_msg_sz        = 8,
    parameter int unsigned p_mem_sz        = 1024,
    parameter int unsigned p_max_delay     = 0,
    parameter logic [15:0] p_lfsr_seed     = 16'hACE1,
    parameter bit          p_stop_on_error = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [$clog2(p_mem_sz)-1:0]   load_addr,
    input  logic [p_msg_sz-1:0]           load_msg,
    input  logic [p_msg_sz-1:0]           load_mask,
    input  logic [$clog2(p_mem_sz):0]     num_msgs,
    input  logic                          start,
    input  logic                          val,
    output logic                          rdy,
    input  logic [p_msg_sz-1:0]           msg,
    output logic                          done,
    output logic                          err,
    output logic [15:0]                   err_count,
    output logic [$clog2(p_mem_sz):0]     recv_count,
    output logic [$clog2(p_mem_sz)-1:0]   first_err_idx
);
    localparam int unsigned AW      = $clog2(p_mem_sz);
    localparam logic [15:0] SEED    = (p_lfsr_seed == 16'h0) ? 16'h1 : p_lfsr_seed;
    localparam logic [AW:0] MEM_SZ  = (AW + 1)'(p_mem_sz);
    localparam logic [8:0]  DLY_MOD = 9'(p_max_delay + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [7:0]      delay_q, delay_d;
    logic [AW:0]     num_lat_q, num_lat_d;
    logic [AW:0]     recv_q, recv_d;
    logic            err_q, err_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [AW-1:0]   first_q, first_d;

    logic [p_msg_sz-1:0] mem_msg_q  [p_mem_sz];
    logic [p_msg_sz-1:0] mem_mask_q [p_mem_sz];
    logic [p_msg_sz-1:0] diff;
    logic                mismatch;
    logic                rdy_c;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [7:0] pick_delay(input logic [7:0] l);
        logic [8:0] r;
        r = {1'b0, l} % DLY_MOD;
        return r[7:0];
    endfunction

    // Expected storage has no reset so a reset between runs keeps the loaded vectors.
    always_ff @(posedge clk) begin
        if (load_en && state_q == S_IDLE) begin
            mem_msg_q[load_addr]  <= load_msg;
            mem_mask_q[load_addr] <= load_mask;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        delay_d   = delay_q;
        num_lat_d = num_lat_q;
        recv_d    = recv_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        rdy_c     = 1'b0;
        diff      = (msg ^ mem_msg_q[recv_q[AW-1:0]]) & ~mem_mask_q[recv_q[AW-1:0]];
        // Written as if/else so unknown message bits fall into the mismatch branch.
        if (diff == '0) mismatch = 1'b0;
        else            mismatch = 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_lat_d = (num_msgs > MEM_SZ) ? MEM_SZ : num_msgs;
                    recv_d    = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    first_d   = '0;
                    delay_d   = pick_delay(lfsr_q[7:0]);
                    state_d   = (num_lat_d == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_next(lfsr_q);
                rdy_c  = (delay_q == 8'd0) && (recv_q < num_lat_q);
                if (delay_q != 8'd0) delay_d = delay_q - 8'd1;
                if (val && rdy_c) begin
                    recv_d  = recv_q + 1'b1;
                    delay_d = pick_delay(lfsr_q[7:0]);
                    if (mismatch) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        err_d = 1'b1;
                        if (!err_q) first_d = recv_q[AW-1:0];
                    end
                    if (recv_d == num_lat_q || (p_stop_on_error && mismatch)) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            delay_q   <= '0;
            num_lat_q <= '0;
            recv_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            delay_q   <= delay_d;
            num_lat_q <= num_lat_d;
            recv_q    <= recv_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
        end
    end

    assign rdy           = rdy_c;
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign err_count     = err_cnt_q;
    assign recv_count    = recv_q;
    assign first_err_idx = first_q;
endmodule
